// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the ALU arbiter slice.
// Holds the arbiter state encoding, default datapath widths and the ALU
// opcode map used by clients and benches.
package alu_arb_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_LE   = 4'b1111;

  // Width of an index able to name any of n requesters (n >= 2).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// alu_rr_pick: combinational winner picker for the ALU arbiter.
// Default: round-robin, search starts one past i_last_grant.
// Macro ALU_ARB_FIXED_PRIO_EN: lowest-index requester always wins and
// i_last_grant is ignored.
module alu_rr_pick
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: scan upward from index 0, first valid requester wins.
  always_comb begin
    logic w_found;
    logic w_hit;
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_hit   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_hit      = i_req[k] & ~w_found;
      o_grant[k] = w_hit;
      o_idx      = w_hit ? IDX_W'(k) : o_idx;
      w_found    = w_found | w_hit;
    end
    o_any = w_found;
  end
`else
  // Round-robin: scan offsets 1..NUM_REQ from the last winner, wrapping,
  // so the previous winner is examined last.
  always_comb begin
    logic             w_found;
    logic             w_hit;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_pos;
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, i_last_grant} + (IDX_W+1)'(k);
      w_sum = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? (w_sum - (IDX_W+1)'(NUM_REQ)) : w_sum;
      w_pos = w_sum[IDX_W-1:0];
      w_hit = i_req[w_pos] & ~w_found;
      o_grant[w_pos] = o_grant[w_pos] | w_hit;
      o_idx   = w_hit ? w_pos : o_idx;
      w_found = w_found | w_hit;
    end
    o_any = w_found;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between NUM_REQ requesters.
// One operation in flight: IDLE (accept) -> EXEC (ALU evaluates registered
// operands) -> RESP (held response until the owner accepts it).
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority in alu_rr_pick.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SEL_W   = DEF_SEL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_A,
  input  logic [NUM_REQ*DATA_W-1:0] req_B,
  input  logic [NUM_REQ*SEL_W-1:0]  req_Sel,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_Out,
  output logic                      rsp_Carry,
  output logic                      rsp_Zero,
  output logic                      rsp_Overflow,
  output logic                      busy,
  output logic [DATA_W-1:0]         ALU_A,
  output logic [DATA_W-1:0]         ALU_B,
  output logic [SEL_W-1:0]          ALU_Sel,
  input  logic [DATA_W-1:0]         ALU_Out,
  input  logic                      CarryOut,
  input  logic                      Zero,
  input  logic                      Overflow
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_e         r_state;
  logic [IDX_W-1:0]   r_owner;
  logic [NUM_REQ-1:0] r_owner_oh;
  logic [IDX_W-1:0]   r_last_grant;
  logic [DATA_W-1:0]  r_alu_a;
  logic [DATA_W-1:0]  r_alu_b;
  logic [SEL_W-1:0]   r_alu_sel;
  logic [DATA_W-1:0]  r_rsp_out;
  logic               r_rsp_carry;
  logic               r_rsp_zero;
  logic               r_rsp_ovf;
  logic [NUM_REQ-1:0] r_rsp_valid;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [DATA_W-1:0]  w_sel_a;
  logic [DATA_W-1:0]  w_sel_b;
  logic [SEL_W-1:0]   w_sel_op;
  logic               w_owner_ready;

  alu_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_idx        (w_idx),
    .o_any        (w_any)
  );

  // AND-OR mux of the winning requester's operands and opcode.
  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_a  = w_sel_a  | (req_A[i*DATA_W +: DATA_W] & {DATA_W{w_grant[i]}});
      w_sel_b  = w_sel_b  | (req_B[i*DATA_W +: DATA_W] & {DATA_W{w_grant[i]}});
      w_sel_op = w_sel_op | (req_Sel[i*SEL_W +: SEL_W] & {SEL_W{w_grant[i]}});
    end
  end

  // Only the owner's rsp_ready can retire the response.
  assign w_owner_ready = |(rsp_ready & r_owner_oh);

  // Accept is combinational so the handshake completes in the IDLE cycle.
  assign req_ready = (r_state == IDLE) ? w_grant : {NUM_REQ{1'b0}};

  // Single FSM: accept/latch in IDLE, capture in EXEC, hold in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_owner_oh   <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= '0;
      r_rsp_out    <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_valid  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_alu_a    <= w_sel_a;
            r_alu_b    <= w_sel_b;
            r_alu_sel  <= w_sel_op;
            r_owner    <= w_idx;
            r_owner_oh <= w_grant;
            r_state    <= EXEC;
          end else begin
            r_state    <= IDLE;
          end
        end
        EXEC: begin
          r_rsp_out   <= ALU_Out;
          r_rsp_carry <= CarryOut;
          r_rsp_zero  <= Zero;
          r_rsp_ovf   <= Overflow;
          r_rsp_valid <= r_owner_oh;
          r_state     <= RESP;
        end
        RESP: begin
          if (w_owner_ready) begin
            r_rsp_valid  <= '0;
            r_last_grant <= r_owner;
            r_state      <= IDLE;
          end else begin
            r_state      <= RESP;
          end
        end
        default: begin
          r_rsp_valid <= '0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign busy         = (r_state != IDLE);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_Out      = r_rsp_out;
  assign rsp_Carry    = r_rsp_carry;
  assign rsp_Zero     = r_rsp_zero;
  assign rsp_Overflow = r_rsp_ovf;
  assign ALU_A        = r_alu_a;
  assign ALU_B        = r_alu_b;
  assign ALU_Sel      = r_alu_sel;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a small
// behavioural ALU (ADD/SUB, AND otherwise) attached to the ALU port.
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_A = '0;
  logic [N*DW-1:0] req_B = '0;
  logic [N*SW-1:0] req_Sel = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [DW-1:0]   rsp_Out;
  logic            rsp_Carry, rsp_Zero, rsp_Overflow, busy;
  logic [DW-1:0]   ALU_A, ALU_B;
  logic [SW-1:0]   ALU_Sel;
  logic [DW-1:0]   ALU_Out;
  logic            CarryOut, Zero, Overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_Sel(req_Sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_Out(rsp_Out), .rsp_Carry(rsp_Carry), .rsp_Zero(rsp_Zero),
    .rsp_Overflow(rsp_Overflow), .busy(busy),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Sel(ALU_Sel),
    .ALU_Out(ALU_Out), .CarryOut(CarryOut), .Zero(Zero), .Overflow(Overflow)
  );

  // Behavioural ALU model driven by the arbiter's registered operands.
  always_comb begin
    ALU_Out  = '0;
    CarryOut = 1'b0;
    Overflow = 1'b0;
    case (ALU_Sel)
      OP_ADD: begin
        {CarryOut, ALU_Out} = {1'b0, ALU_A} + {1'b0, ALU_B};
        Overflow = (ALU_A[DW-1] == ALU_B[DW-1]) && (ALU_Out[DW-1] != ALU_A[DW-1]);
      end
      OP_SUB: begin
        {CarryOut, ALU_Out} = {1'b0, ALU_A} - {1'b0, ALU_B};
        Overflow = (ALU_A[DW-1] != ALU_B[DW-1]) && (ALU_Out[DW-1] != ALU_A[DW-1]);
      end
      default: ALU_Out = ALU_A & ALU_B;
    endcase
    Zero = (ALU_Out == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    req_A[i*DW +: DW]   = a;
    req_B[i*DW +: DW]   = b;
    req_Sel[i*SW +: SW] = s;
  endtask

  // Leaves the DUT freshly out of reset, 1ns after the edge.
  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({req_ready, rsp_valid, busy} !== 9'b0) begin
      failures++;
      $display("FAIL reset_hs: ready=%b rsp_valid=%b busy=%b, want all 0", req_ready, rsp_valid, busy);
    end
    checks++;
    if ({rsp_Out, rsp_Carry, rsp_Zero, rsp_Overflow} !== 11'b0) begin
      failures++;
      $display("FAIL reset_rsp: out=%h c=%b z=%b v=%b, want 0", rsp_Out, rsp_Carry, rsp_Zero, rsp_Overflow);
    end
    checks++;
    if ({ALU_A, ALU_B, ALU_Sel} !== 20'b0) begin
      failures++;
      $display("FAIL reset_alu: A=%h B=%h Sel=%h, want 0", ALU_A, ALU_B, ALU_Sel);
    end
  endtask

  task automatic test_single_op();
    do_reset();
    set_req(0, 8'hAA, 8'h55, OP_ADD);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_accept: req_ready=%b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if ({busy, req_ready, rsp_valid} !== 9'b1_0000_0000 || ALU_A !== 8'hAA || ALU_B !== 8'h55 || ALU_Sel !== 4'h0) begin
      failures++;
      $display("FAIL single_exec: busy=%b ready=%b rv=%b A=%h B=%h Sel=%h want 1/0/0/AA/55/0",
               busy, req_ready, rsp_valid, ALU_A, ALU_B, ALU_Sel);
    end
    tick();
    #1;
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_Out !== 8'hFF || rsp_Carry !== 1'b0 || rsp_Zero !== 1'b0) begin
      failures++;
      $display("FAIL single_resp: rv=%b out=%h c=%b z=%b want 0001/FF/0/0", rsp_valid, rsp_Out, rsp_Carry, rsp_Zero);
    end
    rsp_ready = 4'b1111;
    tick();
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
      failures++;
      $display("FAIL single_retire: busy=%b rv=%b want 0/0000", busy, rsp_valid);
    end
  endtask

  // Runs right after test_single_op: last winner was 0, only requester 2 asks.
  task automatic test_carry_zero();
    set_req(2, 8'hFF, 8'h01, OP_ADD);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL cz_accept: req_ready=%b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    #1;
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_Out !== 8'h00 || rsp_Carry !== 1'b1 || rsp_Zero !== 1'b1 || rsp_Overflow !== 1'b0) begin
      failures++;
      $display("FAIL cz_resp: rv=%b out=%h c=%b z=%b v=%b want 0100/00/1/1/0",
               rsp_valid, rsp_Out, rsp_Carry, rsp_Zero, rsp_Overflow);
    end
    tick();
  endtask

  task automatic test_fairness();
    logic [3:0] exp_rdy;
    logic [3:0] exp_rv;
    logic [7:0] exp_out;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'(i*16 + 1), 8'h01, OP_ADD);
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      #1;
      exp_rdy = (c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
      exp_rv  = (c % 3 == 2) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
      exp_out = 8'(((c / 3) % 4) * 16 + 2);
      checks++;
      if (req_ready !== exp_rdy) begin
        failures++;
        $display("FAIL fair_grant c=%0d: req_ready=%b want %b", c, req_ready, exp_rdy);
      end
      if (c % 3 == 2) begin
        checks++;
        if (rsp_valid !== exp_rv || rsp_Out !== exp_out) begin
          failures++;
          $display("FAIL fair_resp c=%0d: rv=%b out=%h want %b/%h", c, rsp_valid, rsp_Out, exp_rv, exp_out);
        end
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(1, 8'h70, 8'h10, OP_ADD);
    set_req(0, 8'h0F, 8'h01, OP_ADD);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_accept: req_ready=%b want 0010", req_ready);
    end
    tick();
    req_valid = 4'b0001;
    rsp_ready = 4'b1101;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 4'b0010 || rsp_Out !== 8'h80 || rsp_Overflow !== 1'b1 || busy !== 1'b1 || req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_hold c=%0d: rv=%b out=%h v=%b busy=%b ready=%b want 0010/80/1/1/0000",
                 c, rsp_valid, rsp_Out, rsp_Overflow, busy, req_ready);
      end
      tick();
    end
    rsp_ready = 4'b1111;
    tick();
    #1;
    checks++;
    if (req_ready !== 4'b0001 || rsp_valid !== 4'b0000) begin
      failures++;
      $display("FAIL bp_resume: ready=%b rv=%b want 0001/0000", req_ready, rsp_valid);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 4'b1111;
    set_req(3, 8'h12, 8'h34, OP_SUB);
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL rm_accept: req_ready=%b want 1000", req_ready);
    end
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, rsp_valid, req_ready, rsp_Out, rsp_Carry, rsp_Zero, rsp_Overflow, ALU_A, ALU_B, ALU_Sel} !== 0) begin
      failures++;
      $display("FAIL rm_clear: busy=%b rv=%b out=%h A=%h B=%h Sel=%h want all 0",
               busy, rsp_valid, rsp_Out, ALU_A, ALU_B, ALU_Sel);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (rsp_valid !== 4'b0000) begin
        failures++;
        $display("FAIL rm_no_rsp c=%0d: rv=%b want 0000", c, rsp_valid);
      end
    end
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rm_first_grant: req_ready=%b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_fixed_prio();
    logic [3:0] exp_rdy;
    do_reset();
    set_req(0, 8'h01, 8'h01, OP_ADD);
    set_req(3, 8'h02, 8'h02, OP_ADD);
    req_valid = 4'b1001;
    rsp_ready = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      #1;
      exp_rdy = (c % 3 == 0) ? 4'b0001 : 4'b0000;
      checks++;
      if (req_ready !== exp_rdy) begin
        failures++;
        $display("FAIL fixed_grant c=%0d: req_ready=%b want %b", c, req_ready, exp_rdy);
      end
      tick();
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_carry_zero();
`ifdef ALU_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_fairness();
`endif
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 8-bit ALU (A, B, ALU_Sel in; ALU_Out, CarryOut, Zero, Overflow out) between NUM_REQ independent requesters. Accepts one operation at a time via valid/ready, drives registered operands to the ALU, captures the result and flags, and returns them to the issuing requester with a held response handshake. It sits between the ALU and the client blocks and owns all ALU input muxing.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 8: operand/result width. Must match the ALU.
- SEL_W, 4: opcode width. Must match ALU_Sel.

Ports:
- clk  in  1  clock. Every flop updates on the rising edge.
- rst  in  1  reset. Synchronous and active-high.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept. One-hot or zero.
- req_A  in  NUM_REQ*DATA_W  packed operand A. Requester i occupies bits [i*DATA_W +: DATA_W].
- req_B  in  NUM_REQ*DATA_W  packed operand B, same packing.
- req_Sel  in  NUM_REQ*SEL_W  packed opcode.
- rsp_valid  out  NUM_REQ  per-requester response valid. One-hot or zero.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_Out  out  DATA_W  result, shared by all requesters.
- rsp_Carry, rsp_Zero, rsp_Overflow  out  1 each  captured ALU flags.
- busy  out  1  high whenever state is not IDLE.
- ALU_A, ALU_B  out  DATA_W  registered operands to the ALU.
- ALU_Sel  out  SEL_W  registered opcode to the ALU.
- ALU_Out  in  DATA_W  ALU result.
- CarryOut, Zero, Overflow  in  1 each  ALU flags.

## Operation
- FSM with three states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, pick winner w and assert req_ready[w] combinationally in the same cycle. The handshake completes that cycle.
  - On the edge, latch req_A/B/Sel[w] into ALU_A/B/Sel, store the owner id = w, and go to EXEC.
  - If no req_valid is high, stay in IDLE. ALU_A/B/Sel hold their previous values.
- EXEC:
  - The ALU evaluates the registered operands.
  - On the edge, capture ALU_Out/CarryOut/Zero/Overflow into rsp_Out/rsp_Carry/rsp_Zero/rsp_Overflow, and go to RESP.
- RESP:
  - rsp_valid[id] is high. Result outputs are stable.
  - When rsp_ready[id] is high, go to IDLE on the edge and set last_grant = id.
  - rsp_ready of non-owners is ignored.
- Arbitration: round-robin. Search starts at (last_grant+1) mod NUM_REQ. A requester that wins drops to lowest priority.
- req_ready is low in EXEC and RESP. req_valid in those states is ignored, not lost: the request stays pending at the requester.
- The arbiter does not interpret opcodes or flags. Flag semantics are the ALU's.
- Out-of-range requester bits never appear, because the widths are parameterised.

## Timing
- Reset values: state IDLE, last_grant NUM_REQ-1 (requester 0 wins first), req_ready 0, rsp_valid 0, rsp_Out 0, all rsp flags 0, ALU_A/B/Sel 0, busy 0.
- Latency: accept at cycle T, rsp_valid at T+2. With rsp_ready already high at T+2, the next accept is at T+3. Peak throughput is one operation per 3 cycles.
- Back-pressure: while rsp_ready[id] is low, the FSM stays in RESP indefinitely with all outputs unchanged.
- Simultaneous requests are resolved only by the arbitration rule. A pending request of the owner during RESP competes normally in the next IDLE cycle.
- Reset in any state: next cycle all outputs return to their reset values. An in-flight operation is dropped and never responded to.

## Configuration
- ALU_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. The lowest-index valid requester always wins, and last_grant is not used (it may be optimised away).
  - Undefined (default): round-robin as described above.

## Structure
- Package alu_arb_pkg holds:
  - the state enum (IDLE, EXEC, RESP);
  - default DATA_W/SEL_W constants;
  - ALU opcode constants (OP_ADD=4'b0000, OP_SUB=4'b0001, …, OP_LE=4'b1111) for benches and clients.
- One sub-module, alu_rr_pick: a combinational picker with inputs request vector and last_grant, and outputs one-hot grant and encoded index. It contains the ALU_ARB_FIXED_PRIO_EN switch.

## Test plan
- Single op: requester 0 sends A=8'hAA, B=8'h55, Sel=4'b0000 at cycle T → req_ready[0] at T, rsp_valid[0] at T+2, rsp_Out=8'hFF, rsp_Carry=0, rsp_Zero=0.
- Carry/zero passthrough: requester 2 sends A=8'hFF, B=8'h01, Sel=4'b0000 → rsp_Out=8'h00, rsp_Carry=1, rsp_Zero=1, and only rsp_valid[2] is high.
- Fairness: all 4 req_valid held high with rsp_ready tied high → grant order 0,1,2,3,0, with accepts 3 cycles apart.
- Back-pressure: rsp_ready[1] held low for 5 cycles in RESP → rsp_valid[1] and rsp_Out are stable, busy=1, and no req_ready is asserted. Accept resumes the cycle after rsp_ready[1] rises.
- Reset mid-operation: assert rst during EXEC → next cycle all outputs are 0, no rsp_valid ever fires for the dropped op, and the first grant after reset goes to requester 0.
- With ALU_ARB_FIXED_PRIO_EN defined: requesters 0 and 3 held valid → requester 0 wins every arbitration and requester 3 is never granted.
